pio_hull_ctrl_out: RTL

//   Avalon-MM slave output PIO driving the hull motor-driver control lines (enable/brake/reset).

---
 rtl/pio_hull_ctrl_out_if.sv | 11 +
 rtl/pio_hull_ctrl_out.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pio_hull_ctrl_out_if.sv
// Avalon-MM slave bus bundle for the hull control output PIO.
interface pio_hull_ctrl_out_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_hull_ctrl_out.sv
// Output PIO for hull motor-driver control lines: DATA with set/clear strobes, self-timed pulses,
// and an optional communication watchdog enabled by defining PIO_HULL_CTRL_WDT_EN.
module pio_hull_ctrl_out #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] SAFE_VALUE  = '0,
   parameter int unsigned      PULSE_LEN   = 16,
   parameter logic [31:0]      WDT_DEFAULT = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   pio_hull_ctrl_out_if.slave bus,
   output logic [WIDTH-1:0]   out_port
);

   localparam int unsigned CW = $clog2(PULSE_LEN + 1);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [CW-1:0]    pcnt_q, pcnt_d;
   logic [WIDTH-1:0] wd_c;
   logic             wr_c;
   logic             tripped_d;
   logic [31:0]      rd_c;

   assign wr_c = bus.chipselect && !bus.write_n;
   assign wd_c = bus.writedata[WIDTH-1:0];

   // DATA update and pulse timer; a new pulse write wins over expiry in the same cycle
   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      pcnt_d = pcnt_q;
      if (wr_c) begin
         case (bus.address)
            3'd0:    data_d = wd_c;
            3'd4:    data_d = data_q | wd_c;
            3'd5:    data_d = data_q & ~wd_c;
            default: data_d = data_q;
         endcase
      end
      if (wr_c && bus.address == 3'd1 && wd_c != '0) begin
         mask_d = mask_q | wd_c;
         pcnt_d = CW'(PULSE_LEN);
      end else if (pcnt_q != '0) begin
         pcnt_d = pcnt_q - CW'(1);
         if (pcnt_q == CW'(1)) mask_d = '0;
      end
   end

`ifdef PIO_HULL_CTRL_WDT_EN
   logic [31:0] reload_q, reload_d;
   logic [31:0] wcnt_q, wcnt_d;
   logic        tripped_q;
   logic        kick_c;
   logic        clr_c;

   assign kick_c = wr_c && (bus.address inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
   assign clr_c  = wr_c && bus.address == 3'd3 && bus.writedata[0];

   // Watchdog: status clear beats expiry, any kick reloads, trip is sticky
   always_comb begin
      reload_d  = (wr_c && bus.address == 3'd2) ? bus.writedata : reload_q;
      wcnt_d    = wcnt_q;
      tripped_d = tripped_q;
      if (clr_c) begin
         tripped_d = 1'b0;
         wcnt_d    = reload_q;
      end else if (kick_c) begin
         wcnt_d = reload_d;
      end else if (reload_q != 32'd0 && !tripped_q) begin
         wcnt_d = (wcnt_q == 32'd0) ? 32'd0 : wcnt_q - 32'd1;
         if (wcnt_q <= 32'd1) tripped_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reload_q  <= WDT_DEFAULT;
         wcnt_q    <= WDT_DEFAULT;
         tripped_q <= 1'b0;
      end else begin
         reload_q  <= reload_d;
         wcnt_q    <= wcnt_d;
         tripped_q <= tripped_d;
      end
   end
`else
   logic unused_c;

   assign tripped_d = 1'b0;
   assign unused_c  = ^{bus.writedata, WDT_DEFAULT};
`endif

   // Read mux sampled every cycle from current register state
   always_comb begin
      rd_c = 32'd0;
      case (bus.address)
         3'd0:    rd_c = 32'(data_q);
         3'd1:    rd_c = 32'(mask_q);
`ifdef PIO_HULL_CTRL_WDT_EN
         3'd2:    rd_c = reload_q;
         3'd3:    rd_c = {31'd0, tripped_q};
`endif
         default: rd_c = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q       <= RESET_VALUE;
         mask_q       <= '0;
         pcnt_q       <= '0;
         out_port     <= RESET_VALUE;
         bus.readdata <= 32'd0;
      end else begin
         data_q       <= data_d;
         mask_q       <= mask_d;
         pcnt_q       <= pcnt_d;
         out_port     <= tripped_d ? SAFE_VALUE : (data_d | mask_d);
         bus.readdata <= rd_c;
      end
   end

endmodule
